bcd_stopwatch: RTL and testbench
================================

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, giving the clk cycles per 1 ms count (50 MHz clk).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  synchronous level, sampled each edge; begins or resumes counting.
REQ-005 SHALL have port stop  input  1  synchronous level; pauses counting and holds the displayed value.
REQ-006 SHALL have port clear  input  1  synchronous level; zeroes the digits and returns to IDLE.
REQ-007 SHALL have port ones  output  4  BCD seconds digit, 0-9.
REQ-008 SHALL have port tenths  output  4  BCD 0.1 s digit, 0-9.
REQ-009 SHALL have port hundreths  output  4  BCD 0.01 s digit, 0-9.
REQ-010 SHALL have port thousandths  output  4  BCD 0.001 s digit, 0-9.
REQ-011 SHALL have port running  output  1  high only in state RUN.
REQ-012 SHALL have port overflow  output  1  high only in state OVF.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD and OVF, all registered.
REQ-014 SHALL apply command priority clear > stop > start when several are high in the same cycle.
REQ-015 SHALL make these transitions: IDLE-start->RUN; RUN-stop->HOLD; HOLD-start->RUN; any state-clear->IDLE; RUN-increment at 9.999->OVF.
REQ-016 SHALL ignore start in RUN and OVF, and ignore stop in IDLE, HOLD and OVF.
REQ-017 SHALL run the prescaler from 0 to TICK_DIV-1 only in RUN; the prescaler wraps to 0 at the terminal count.
REQ-018 SHALL increment the digits once per prescaler terminal count.
REQ-019 SHALL make the new digit value visible on the edge on which the prescaler wraps.
REQ-020 SHALL hold the prescaler value in HOLD, so that a resume continues the partial millisecond.
REQ-021 SHALL zero the prescaler on clear and on the IDLE->RUN transition.
REQ-022 SHALL increment as decimal BCD: thousandths 9->0 carries into hundreths, 9->0 carries into tenths, 9->0 carries into ones.
REQ-023 SHALL keep every digit in 0-9 at all times; no digit ever takes a value from 10 to 15.
REQ-024 SHALL, on an increment with all digits at 9 (9.999), leave the digits saturated at 9.999 and enter OVF.
REQ-025 SHALL hold the digits in HOLD and OVF.
REQ-026 SHALL, on clear, set all digits to 0 on the next edge.
REQ-027 SHALL give clear the win when clear is high on the same edge as a terminal count: the digits go to 0 and no increment is applied.
REQ-028 SHALL give stop the win when stop is high on the same edge as a terminal count: the state goes to HOLD and the increment is not applied.
REQ-029 SHALL drive running and overflow directly from state registers, with no combinational path from the inputs.
REQ-030 SHALL drive the digit outputs directly from registers, so they are glitch-free into the seven-segment decoder.

Reset
REQ-031 SHALL, on rst high and without waiting for clk, force state IDLE, all digits 0, prescaler 0, running 0 and overflow 0.
REQ-032 SHALL, when rst asserts mid-count in any state, discard the count and resume operation only from IDLE.
REQ-033 SHALL, after rst deasserts, ignore commands until the first rising clk edge.

Verification (TICK_DIV=4 for all scenarios)
REQ-034 SHALL cover: rst; start pulse 1 cycle; 40 cycles elapse -> digits 0.010, running=1.
REQ-035 SHALL cover: count to 0.009, then 4 more cycles -> thousandths 0 and hundreths 1 on the same edge; check the carry chain through 0.099->0.100 and 0.999->1.000.
REQ-036 SHALL cover: stop at 0.005 after 2 prescaler cycles, hold 100 cycles, then start -> digits remain 0.005 while paused and reach 0.006 exactly 2 cycles after resume.
REQ-037 SHALL cover: run to 9.999, then 4 more cycles -> digits remain 9.999 and overflow=1; a later start is ignored; clear -> digits 0.000, overflow=0, state IDLE.
REQ-038 SHALL cover: start, stop and clear all high in one cycle during RUN -> IDLE with digits 0; separately, stop coincident with a terminal count -> HOLD with no increment.
REQ-039 SHALL cover: rst asserted mid-cycle (between edges) while in RUN at 3.141 -> all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (0.000 to 9.999 s) with a millisecond prescaler.
// Command priority is clear > stop > start; the count saturates at 9.999 and the block enters OVF.
module bcd_stopwatch #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] ones,
    output logic [3:0] tenths,
    output logic [3:0] hundreths,
    output logic [3:0] thousandths,
    output logic       running,
    output logic       overflow
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [1:0] OVF  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tenths_q, tenths_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    thou_q, thou_d;
    logic          running_q, running_d;
    logic          overflow_q, overflow_d;

    logic          tc;
    logic          all_nine;

    assign tc       = (presc_q == PW'(TICK_DIV - 1));
    assign all_nine = (ones_q == 4'd9) && (tenths_q == 4'd9) &&
                      (hund_q == 4'd9) && (thou_q == 4'd9);

    // Next state, prescaler and BCD carry chain
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        ones_d   = ones_q;
        tenths_d = tenths_q;
        hund_d   = hund_q;
        thou_d   = thou_q;

        if (clear) begin
            state_d  = IDLE;
            presc_d  = '0;
            ones_d   = 4'd0;
            tenths_d = 4'd0;
            hund_d   = 4'd0;
            thou_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = HOLD;
                    end else if (tc) begin
                        presc_d = '0;
                        if (all_nine) begin
                            state_d = OVF;
                        end else if (thou_q != 4'd9) begin
                            thou_d = 4'(thou_q + 4'd1);
                        end else begin
                            thou_d = 4'd0;
                            if (hund_q != 4'd9) begin
                                hund_d = 4'(hund_q + 4'd1);
                            end else begin
                                hund_d = 4'd0;
                                if (tenths_q != 4'd9) begin
                                    tenths_d = 4'(tenths_q + 4'd1);
                                end else begin
                                    tenths_d = 4'd0;
                                    ones_d   = 4'(ones_q + 4'd1);
                                end
                            end
                        end
                    end else begin
                        presc_d = PW'(presc_q + PW'(1));
                    end
                end
                HOLD: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                OVF: begin
                    state_d = OVF;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d  = (state_d == RUN);
        overflow_d = (state_d == OVF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            ones_q     <= 4'd0;
            tenths_q   <= 4'd0;
            hund_q     <= 4'd0;
            thou_q     <= 4'd0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ones_q     <= ones_d;
            tenths_q   <= tenths_d;
            hund_q     <= hund_d;
            thou_q     <= thou_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    assign ones        = ones_q;
    assign tenths      = tenths_q;
    assign hundreths   = hund_q;
    assign thousandths = thou_q;
    assign running     = running_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch at TICK_DIV=4: expectations are queued as stimulus is
// driven and popped against the registered outputs 1 ns after each rising edge.
module tb_bcd_stopwatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] ones;
    logic [3:0] tenths;
    logic [3:0] hundreths;
    logic [3:0] thousandths;
    logic       running;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t sb[$];

    bcd_stopwatch #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .ones       (ones),
        .tenths     (tenths),
        .hundreths  (hundreths),
        .thousandths(thousandths),
        .running    (running),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int ms);
        to_bcd = {4'(ms / 1000), 4'((ms / 100) % 10), 4'((ms / 10) % 10), 4'(ms % 10)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int ms, input logic run, input logic ovf);
        exp_t e;
        e.tag = tag;
        e.val = {to_bcd(ms), run, ovf};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t        e;
        logic [17:0] obs;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: observed empty queue, required a pending expectation");
        end else begin
            e   = sb.pop_front();
            obs = {ones, tenths, hundreths, thousandths, running, overflow};
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed digits=%h run=%b ovf=%b, expected digits=%h run=%b ovf=%b",
                       e.tag, obs[17:2], obs[1], obs[0], e.val[17:2], e.val[1], e.val[0]);
            end
        end
    endtask

    task automatic pulse(input logic s, input logic p, input logic c);
        start = s;
        stop  = p;
        clear = c;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        #2;
        expect_out("reset_async", 0, 1'b0, 1'b0); check();
        step(2);
        rst = 1'b0;

        pulse(1'b0, 1'b1, 1'b0);
        expect_out("stop_in_idle", 0, 1'b0, 1'b0); check();

        // Start edge resets the prescaler; each 4 further edges add 1 ms
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("first_edge", 0, 1'b1, 1'b0); step(0); check();
        step(36);
        expect_out("at_0009", 9, 1'b1, 1'b0); check();
        step(3);
        expect_out("0009_partial", 9, 1'b1, 1'b0); check();
        step(1);
        expect_out("carry_0010", 10, 1'b1, 1'b0); check();
        step(89 * 4);
        expect_out("at_0099", 99, 1'b1, 1'b0); check();
        step(4);
        expect_out("carry_0100", 100, 1'b1, 1'b0); check();
        step(899 * 4);
        expect_out("at_0999", 999, 1'b1, 1'b0); check();
        step(4);
        expect_out("carry_1000", 1000, 1'b1, 1'b0); check();
        step(2141 * 4);
        expect_out("at_3141", 3141, 1'b1, 1'b0); check();

        step(2);
        #3;
        rst = 1'b1;
        #1;
        expect_out("rst_midcycle", 0, 1'b0, 1'b0); check();
        step(1);
        rst = 1'b0;
        step(1);
        expect_out("idle_after_rst", 0, 1'b0, 1'b0); check();

        // Pause mid-millisecond and resume the partial count
        pulse(1'b1, 1'b0, 1'b0);
        step(20);
        expect_out("at_0005", 5, 1'b1, 1'b0); check();
        step(2);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("hold_entry", 5, 1'b0, 1'b0); check();
        step(100);
        expect_out("hold_100", 5, 1'b0, 1'b0); check();
        pulse(1'b1, 1'b0, 1'b0);
        expect_out("resume_edge", 5, 1'b1, 1'b0); check();
        step(1);
        expect_out("resume_plus1", 5, 1'b1, 1'b0); check();
        step(1);
        expect_out("resume_plus2", 6, 1'b1, 1'b0); check();

        step(3);
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("stop_on_tc", 6, 1'b0, 1'b0); check();
        pulse(1'b1, 1'b0, 1'b0);
        step(1);
        expect_out("resume_after_tc", 7, 1'b1, 1'b0); check();

        pulse(1'b1, 1'b1, 1'b1);
        expect_out("all_cmds", 0, 1'b0, 1'b0); check();

        pulse(1'b1, 1'b0, 1'b0);
        step(8 + 3);
        expect_out("pre_clear_tc", 2, 1'b1, 1'b0); check();
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("clear_on_tc", 0, 1'b0, 1'b0); check();

        // Saturation at 9.999
        pulse(1'b1, 1'b0, 1'b0);
        step(9999 * 4);
        expect_out("at_9999", 9999, 1'b1, 1'b0); check();
        step(3);
        expect_out("9999_partial", 9999, 1'b1, 1'b0); check();
        step(1);
        expect_out("overflow", 9999, 1'b0, 1'b1); check();
        pulse(1'b1, 1'b0, 1'b0);
        step(10);
        expect_out("ovf_ignores_start", 9999, 1'b0, 1'b1); check();
        pulse(1'b0, 1'b1, 1'b0);
        expect_out("ovf_ignores_stop", 9999, 1'b0, 1'b1); check();
        pulse(1'b0, 1'b0, 1'b1);
        expect_out("clear_from_ovf", 0, 1'b0, 1'b0); check();
        pulse(1'b1, 1'b0, 1'b0);
        step(4);
        expect_out("restart_after_ovf", 1, 1'b1, 1'b0); check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
